// File: rtl/meta_pkg.sv
// Shared constants for the metadata streamer: token codes, stream layout and FSM states.
package meta_pkg;

  localparam int LEN = 47;

  localparam logic [7:0] TOK_NAME       = 8'h01;
  localparam logic [7:0] TOK_FW         = 8'h02;
  localparam logic [7:0] TOK_SAMPLE_MEM = 8'h21;
  localparam logic [7:0] TOK_MAX_RATE   = 8'h23;
  localparam logic [7:0] TOK_PROBES     = 8'h40;
  localparam logic [7:0] TOK_PROTO      = 8'h41;
  localparam logic [7:0] TOK_END        = 8'h00;

  localparam int OFS_NAME       = 0;
  localparam int OFS_FW         = 26;
  localparam int OFS_SAMPLE_MEM = 32;
  localparam int OFS_MAX_RATE   = 37;
  localparam int OFS_PROBES     = 42;
  localparam int OFS_PROTO      = 44;
  localparam int OFS_END        = 46;

  localparam int NAME_LEN = 24;
  localparam int FW_LEN   = 4;

  localparam logic [8*NAME_LEN-1:0] NAME_STR = "Open Logic Sniffer v1.01";
  localparam logic [8*FW_LEN-1:0]   FW_STR   = "3.07";

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    POLL
  } meta_state_t;

  // Byte k of a 32-bit word, most significant byte first.
  function automatic logic [7:0] word_byte(input logic [31:0] word, input int k);
    case (k)
      0:       word_byte = word[31:24];
      1:       word_byte = word[23:16];
      2:       word_byte = word[15:8];
      default: word_byte = word[7:0];
    endcase
  endfunction

  function automatic logic [7:0] name_byte(input int k);
    logic [8*NAME_LEN-1:0] shifted;
    shifted   = NAME_STR << (8 * k);
    name_byte = shifted[8*NAME_LEN-1 -: 8];
  endfunction

endpackage

// File: rtl/meta_rom.sv
// Metadata byte lookup: maps a stream index to its byte, patching in the numeric fields.
// Define META_DYNAMIC_EN to take sample-memory size and probe count from the runtime ports.
module meta_rom
  import meta_pkg::*;
#(
  parameter int ROM_DEPTH  = 64,
  parameter int SAMPLE_MEM = 24576,
  parameter int MAX_RATE   = 200000000,
  parameter int MAX_PROBES = 32,
  parameter int PROTO_VER  = 2,
  parameter int IDX_W      = $clog2(ROM_DEPTH)
) (
  input  logic [IDX_W-1:0] index,
  input  logic [31:0]      mem_size,
  input  logic [7:0]       probe_count,
  output logic [7:0]       meta_data
);

  localparam logic [31:0] RATE_WORD  = 32'(MAX_RATE);
  localparam logic [7:0]  PROTO_BYTE = 8'(PROTO_VER);

  logic [31:0] mem_field;
  logic [7:0]  probe_field;
  int          pos;

`ifdef META_DYNAMIC_EN
  assign mem_field   = mem_size;
  assign probe_field = probe_count;
`else
  logic unused_dynamic;
  assign unused_dynamic = ^{mem_size, probe_count};
  assign mem_field      = 32'(SAMPLE_MEM);
  assign probe_field    = 8'(MAX_PROBES);
`endif

  assign pos = int'(index);

  // Every index not claimed by a field, including the terminators and the unused tail, reads 0x00.
  always_comb begin
    meta_data = TOK_END;
    if (pos == OFS_NAME) begin
      meta_data = TOK_NAME;
    end else if (pos <= OFS_NAME + NAME_LEN) begin
      meta_data = name_byte(pos - OFS_NAME - 1);
    end else if (pos == OFS_FW) begin
      meta_data = TOK_FW;
    end else if (pos > OFS_FW && pos <= OFS_FW + FW_LEN) begin
      meta_data = word_byte(FW_STR, pos - OFS_FW - 1);
    end else if (pos == OFS_SAMPLE_MEM) begin
      meta_data = TOK_SAMPLE_MEM;
    end else if (pos > OFS_SAMPLE_MEM && pos <= OFS_SAMPLE_MEM + 4) begin
      meta_data = word_byte(mem_field, pos - OFS_SAMPLE_MEM - 1);
    end else if (pos == OFS_MAX_RATE) begin
      meta_data = TOK_MAX_RATE;
    end else if (pos > OFS_MAX_RATE && pos <= OFS_MAX_RATE + 4) begin
      meta_data = word_byte(RATE_WORD, pos - OFS_MAX_RATE - 1);
    end else if (pos == OFS_PROBES) begin
      meta_data = TOK_PROBES;
    end else if (pos == OFS_PROBES + 1) begin
      meta_data = probe_field;
    end else if (pos == OFS_PROTO) begin
      meta_data = TOK_PROTO;
    end else if (pos == OFS_PROTO + 1) begin
      meta_data = PROTO_BYTE;
    end
  end

endmodule

// File: rtl/meta_streamer.sv
// Streams the fixed-layout metadata block one byte per transmitter handshake.
// META_DYNAMIC_EN (optional) sources memory size and probe count from the runtime ports.
module meta_streamer
  import meta_pkg::*;
#(
  parameter int ROM_DEPTH  = 64,
  parameter int SAMPLE_MEM = 24576,
  parameter int MAX_RATE   = 200000000,
  parameter int MAX_PROBES = 32,
  parameter int PROTO_VER  = 2
) (
  input  logic        clock,
  input  logic        extReset,
  input  logic        query_metadata,
  input  logic        abort,
  input  logic        xmit_idle,
  input  logic [31:0] mem_size,
  input  logic [7:0]  probe_count,
  output logic        writeMeta,
  output logic [7:0]  meta_data,
  output logic        busy,
  output logic        done
);

  localparam int                IDX_W    = $clog2(ROM_DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LEN);

  if (ROM_DEPTH < LEN) begin : g_depth_too_small
    $error("meta_streamer: ROM_DEPTH must hold the whole metadata block");
  end
  if ((ROM_DEPTH & (ROM_DEPTH - 1)) != 0) begin : g_depth_not_pow2
    $error("meta_streamer: ROM_DEPTH must be a power of two");
  end

  meta_state_t      state;
  logic [IDX_W-1:0] index;

  // Abort pulls the FSM back to IDLE from anywhere, clearing the index so the next request starts at byte 0.
  always_ff @(posedge clock or posedge extReset) begin
    if (extReset) begin
      state <= IDLE;
      index <= '0;
    end else begin
      case (state)
        IDLE: begin
          index <= '0;
          if (query_metadata && xmit_idle && !abort) begin
            state <= SEND;
          end
        end
        SEND: begin
          if (abort) begin
            state <= IDLE;
            index <= '0;
          end else begin
            state <= POLL;
            index <= index + 1'b1;
          end
        end
        POLL: begin
          if (abort) begin
            state <= IDLE;
            index <= '0;
          end else if (xmit_idle) begin
            if (index == LAST_IDX) begin
              state <= IDLE;
              index <= '0;
            end else begin
              state <= SEND;
            end
          end
        end
        default: begin
          state <= IDLE;
          index <= '0;
        end
      endcase
    end
  end

  // Strobe and done decode straight from state so an abort can suppress them in the same cycle.
  assign writeMeta = (state == SEND) && !abort;
  assign done      = (state == POLL) && xmit_idle && !abort && (index == LAST_IDX);
  assign busy      = (state != IDLE);

  meta_rom #(
    .ROM_DEPTH (ROM_DEPTH),
    .SAMPLE_MEM(SAMPLE_MEM),
    .MAX_RATE  (MAX_RATE),
    .MAX_PROBES(MAX_PROBES),
    .PROTO_VER (PROTO_VER),
    .IDX_W     (IDX_W)
  ) u_rom (
    .index      (index),
    .mem_size   (mem_size),
    .probe_count(probe_count),
    .meta_data  (meta_data)
  );

endmodule

// File: tb/tb_meta_streamer.sv
// Directed bench for meta_streamer: full stream, backpressure, abort and mid-stream reset.
module tb_meta_streamer;

  logic        clock = 1'b0;
  logic        extReset = 1'b1;
  logic        query_metadata = 1'b0;
  logic        abort = 1'b0;
  logic        xmit_idle = 1'b0;
  logic [31:0] mem_size = 32'h0001_0000;
  logic [7:0]  probe_count = 8'd16;
  logic        writeMeta;
  logic [7:0]  meta_data;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_bytes [47];

  always #5 clock = ~clock;

  meta_streamer dut (
    .clock         (clock),
    .extReset      (extReset),
    .query_metadata(query_metadata),
    .abort         (abort),
    .xmit_idle     (xmit_idle),
    .mem_size      (mem_size),
    .probe_count   (probe_count),
    .writeMeta     (writeMeta),
    .meta_data     (meta_data),
    .busy          (busy),
    .done          (done)
  );

  task automatic tick;
    @(posedge clock);
    #2;
  endtask

  task automatic build_expected;
    string name;
    string ver;
    name = "Open Logic Sniffer v1.01";
    ver  = "3.07";
    exp_bytes[0] = 8'h01;
    for (int i = 0; i < 24; i++) exp_bytes[1 + i] = name[i];
    exp_bytes[25] = 8'h00;
    exp_bytes[26] = 8'h02;
    for (int i = 0; i < 4; i++) exp_bytes[27 + i] = ver[i];
    exp_bytes[31] = 8'h00;
    exp_bytes[32] = 8'h21;
`ifdef META_DYNAMIC_EN
    exp_bytes[33] = 8'h00; exp_bytes[34] = 8'h01; exp_bytes[35] = 8'h00; exp_bytes[36] = 8'h00;
    exp_bytes[43] = 8'h10;
`else
    exp_bytes[33] = 8'h00; exp_bytes[34] = 8'h00; exp_bytes[35] = 8'h60; exp_bytes[36] = 8'h00;
    exp_bytes[43] = 8'h20;
`endif
    exp_bytes[37] = 8'h23;
    exp_bytes[38] = 8'h0B; exp_bytes[39] = 8'hEB; exp_bytes[40] = 8'hC2; exp_bytes[41] = 8'h00;
    exp_bytes[42] = 8'h40;
    exp_bytes[44] = 8'h41;
    exp_bytes[45] = 8'h02;
    exp_bytes[46] = 8'h00;
  endtask

  task automatic test_reset;
    extReset = 1'b1; query_metadata = 1'b1; xmit_idle = 1'b1; abort = 1'b0;
    repeat (3) tick;
    checks++; if (writeMeta !== 1'b0) begin errors++; $display("[TB] FAIL reset writeMeta: got %b expected 0", writeMeta); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset done: got %b expected 0", done); end
    checks++; if (meta_data !== 8'h01) begin errors++; $display("[TB] FAIL reset meta_data: got %h expected 01", meta_data); end
  endtask

  task automatic test_full_stream;
    int n = 0;
    int last = 0;
    bit got_done = 1'b0;
    extReset = 1'b0;
    for (int c = 1; c <= 200 && !got_done; c++) begin
      tick;
      if (writeMeta === 1'b1) begin
        checks++;
        if (n >= 47) begin
          errors++; $display("[TB] FAIL extra strobe: got strobe %0d expected at most 47", n + 1);
        end else if (meta_data !== exp_bytes[n]) begin
          errors++; $display("[TB] FAIL stream byte %0d: got %h expected %h", n, meta_data, exp_bytes[n]);
        end
        checks++;
        if ((c - last) !== ((n == 0) ? 1 : 2)) begin
          errors++; $display("[TB] FAIL strobe spacing %0d: got %0d expected %0d", n, c - last, (n == 0) ? 1 : 2);
        end
        last = c;
        n++;
      end
      if (done === 1'b1) begin
        got_done = 1'b1;
        checks++; if (n !== 47) begin errors++; $display("[TB] FAIL strobes before done: got %0d expected 47", n); end
      end
    end
    checks++; if (!got_done) begin errors++; $display("[TB] FAIL done pulse: got none expected one within 200 cycles"); end
    tick;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL busy after done: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL done width: got %b expected 0", done); end
    tick;
    checks++; if (writeMeta !== 1'b1 || meta_data !== 8'h01) begin
      errors++; $display("[TB] FAIL held request restart: got %b/%h expected 1/01", writeMeta, meta_data);
    end
    query_metadata = 1'b0; abort = 1'b1; #1;
    checks++; if (writeMeta !== 1'b0) begin errors++; $display("[TB] FAIL abort in SEND writeMeta: got %b expected 0", writeMeta); end
    tick;
    abort = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL busy after abort: got %b expected 0", busy); end
  endtask

  task automatic test_abort_idle;
    query_metadata = 1'b1; abort = 1'b1;
    repeat (3) begin
      tick;
      checks++; if (busy !== 1'b0 || writeMeta !== 1'b0) begin
        errors++; $display("[TB] FAIL abort with request: got busy %b strobe %b expected 0/0", busy, writeMeta);
      end
    end
    abort = 1'b0;
    tick;
    checks++; if (writeMeta !== 1'b1 || meta_data !== 8'h01) begin
      errors++; $display("[TB] FAIL start after abort release: got %b/%h expected 1/01", writeMeta, meta_data);
    end
    query_metadata = 1'b0; abort = 1'b1;
    tick;
    abort = 1'b0;
  endtask

  task automatic test_abort_mid;
    int n = 0;
    int bad = 0;
    query_metadata = 1'b1;
    for (int c = 0; c < 60 && n < 10; c++) begin
      tick;
      if (writeMeta === 1'b1) n++;
    end
    checks++; if (n !== 10) begin errors++; $display("[TB] FAIL reach 10 strobes: got %0d expected 10", n); end
    tick;
    abort = 1'b1; query_metadata = 1'b0; #1;
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL done on abort: got %b expected 0", done); end
    tick;
    abort = 1'b0;
    repeat (30) begin
      tick;
      if (writeMeta !== 1'b0 || done !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL quiet after abort: got %0d active cycles expected 0", bad); end
    query_metadata = 1'b1;
    tick;
    checks++; if (writeMeta !== 1'b1 || meta_data !== 8'h01) begin
      errors++; $display("[TB] FAIL restart after abort: got %b/%h expected 1/01", writeMeta, meta_data);
    end
    query_metadata = 1'b0; abort = 1'b1;
    tick;
    abort = 1'b0;
  endtask

  task automatic test_backpressure;
    int n = 0;
    int strobes = 0;
    int idle_drops = 0;
    query_metadata = 1'b1;
    for (int c = 0; c < 30 && n < 3; c++) begin
      tick;
      if (writeMeta === 1'b1) n++;
    end
    checks++; if (n !== 3 || meta_data !== exp_bytes[2]) begin
      errors++; $display("[TB] FAIL third strobe: got %0d strobes byte %h expected 3 strobes byte %h", n, meta_data, exp_bytes[2]);
    end
    xmit_idle = 1'b0;
    repeat (5) begin
      tick;
      if (writeMeta !== 1'b0) strobes++;
      if (busy !== 1'b1) idle_drops++;
    end
    checks++; if (strobes !== 0) begin errors++; $display("[TB] FAIL strobes while not idle: got %0d expected 0", strobes); end
    checks++; if (idle_drops !== 0) begin errors++; $display("[TB] FAIL busy while held: got %0d low cycles expected 0", idle_drops); end
    xmit_idle = 1'b1;
    tick;
    checks++; if (writeMeta !== 1'b1 || meta_data !== exp_bytes[3]) begin
      errors++; $display("[TB] FAIL resume byte 3: got %b/%h expected 1/%h", writeMeta, meta_data, exp_bytes[3]);
    end
    query_metadata = 1'b0; abort = 1'b1;
    tick;
    abort = 1'b0;
  endtask

  task automatic test_reset_mid;
    int n = 0;
    query_metadata = 1'b1;
    for (int c = 0; c < 100 && n < 20; c++) begin
      tick;
      if (writeMeta === 1'b1) n++;
    end
    checks++; if (n !== 20) begin errors++; $display("[TB] FAIL reach 20 strobes: got %0d expected 20", n); end
    extReset = 1'b1; #1;
    checks++; if (writeMeta !== 1'b0) begin errors++; $display("[TB] FAIL async reset writeMeta: got %b expected 0", writeMeta); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL async reset busy: got %b expected 0", busy); end
    checks++; if (meta_data !== 8'h01) begin errors++; $display("[TB] FAIL async reset meta_data: got %h expected 01", meta_data); end
    tick;
    extReset = 1'b0;
    tick;
    checks++; if (writeMeta !== 1'b1 || meta_data !== 8'h01) begin
      errors++; $display("[TB] FAIL restart after reset: got %b/%h expected 1/01", writeMeta, meta_data);
    end
    query_metadata = 1'b0; abort = 1'b1;
    tick;
    abort = 1'b0;
  endtask

  initial begin
    build_expected;
    test_reset;
    test_full_stream;
    test_abort_idle;
    test_abort_mid;
    test_backpressure;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
